// File: rtl/uart_pkg.sv
// Shared UART constants, FSM state types and the parity helper.
// No timing of its own; pure definitions used by the transceiver core.
// No flow control.
package uart_pkg;
  localparam int MAX_W = 9;

  localparam logic [1:0] PARI_NONE = 2'b00;
  localparam logic [1:0] PARI_ODD  = 2'b01;
  localparam logic [1:0] PARI_EVEN = 2'b10;

  typedef enum logic [2:0] {
    TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP1, TX_STOP2
  } tx_state_t;

  typedef enum logic [2:0] {
    RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP
  } rx_state_t;

  function automatic logic pari_on(input logic [1:0] mode);
    return (mode == PARI_ODD) || (mode == PARI_EVEN);
  endfunction

  // Parity over the low w bits of d; mode 11 falls through as even but is never sent.
  function automatic logic pari_bit(input logic [MAX_W-1:0] d, input int w,
                                    input logic [1:0] mode);
    logic x;
    x = 1'b0;
    for (int i = 0; i < MAX_W; i++)
      if (i < w) x = x ^ d[i];
    return (mode == PARI_ODD) ? ~x : x;
  endfunction
endpackage

// File: rtl/uart_tick_gen.sv
// Oversample tick divider: one-cycle tick every r_div+1 clk cycles.
// Tick asserts combinationally from the counter state; no added latency.
// No backpressure; free-running.
module uart_tick_gen #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [DIV_W-1:0] r_div,
  output logic             tick
);
  logic [DIV_W-1:0] cnt;

  // >= rather than == so a divisor lowered below the count still wraps.
  assign tick = (cnt >= r_div);

  always_ff @(posedge clk) begin
    if (rst)       cnt <= '0;
    else if (tick) cnt <= '0;
    else           cnt <= cnt + DIV_W'(1);
  end
endmodule

// File: rtl/uart_core_param.sv
// Parametrised full-duplex UART; optional internal loopback under UART_LOOPBACK_EN.
// RX result 2 sync cycles + mid-stop vote; TX line follows state with no extra delay.
// TX accepts via tx_valid/tx_ready only in IDLE; RX has no backpressure.
module uart_core_param import uart_pkg::*; #(
  parameter int DATA_W = 8,
  parameter int DIV_W  = 16,
  parameter int OVS    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rs232_rx,
  output logic              rs232_tx,
  input  logic              r_tx_en,
  input  logic              r_rx_en,
  input  logic [1:0]        r_pari_mode,
  input  logic              r_stop2,
  input  logic [DIV_W-1:0]  r_div,
  input  logic              r_loop,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              pari_err,
  output logic              frame_err,
  output logic              int_tx_finish,
  output logic              int_rx_finish
);
  localparam int SUB_W = $clog2(OVS);
  localparam int BIT_W = $clog2(DATA_W);
  localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(OVS - 1);
  localparam logic [SUB_W-1:0] SUB_VA   = SUB_W'(OVS / 2 - 1);
  localparam logic [SUB_W-1:0] SUB_VB   = SUB_W'(OVS / 2);
  localparam logic [SUB_W-1:0] SUB_VC   = SUB_W'(OVS / 2 + 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);

  logic tick, tx_line, rx_src;

  uart_tick_gen #(.DIV_W(DIV_W)) u_tick (
    .clk   (clk),
    .rst   (rst),
    .r_div (r_div),
    .tick  (tick)
  );

`ifdef UART_LOOPBACK_EN
  assign rx_src   = r_loop ? tx_line : rs232_rx;
  assign rs232_tx = r_loop ? 1'b1 : tx_line;
`else
  logic unused_loop;
  assign unused_loop = r_loop;
  assign rx_src      = rs232_rx;
  assign rs232_tx    = tx_line;
`endif

  // ---------------- transmitter ----------------
  tx_state_t         tx_state, tx_next;
  logic [SUB_W-1:0]  tx_sub;
  logic [BIT_W-1:0]  tx_bit;
  logic [DATA_W-1:0] tx_shreg;
  logic [1:0]        tx_mode;
  logic              tx_stop2, tx_par;
  logic              tx_fire, tx_bit_done;

  assign tx_fire     = tx_valid & tx_ready;
  assign tx_bit_done = tick & (tx_sub == SUB_LAST);

  always_ff @(posedge clk) begin
    if (rst) tx_state <= TX_IDLE;
    else     tx_state <= tx_next;
  end

  always_comb begin
    tx_next = tx_state;
    case (tx_state)
      TX_IDLE:   if (tx_fire) tx_next = TX_START;
      TX_START:  if (tx_bit_done) tx_next = TX_DATA;
      TX_DATA:   if (tx_bit_done && tx_bit == BIT_LAST)
                   tx_next = pari_on(tx_mode) ? TX_PARITY : TX_STOP1;
      TX_PARITY: if (tx_bit_done) tx_next = TX_STOP1;
      TX_STOP1:  if (tx_bit_done) tx_next = tx_stop2 ? TX_STOP2 : TX_IDLE;
      TX_STOP2:  if (tx_bit_done) tx_next = TX_IDLE;
      default:   tx_next = TX_IDLE;
    endcase
  end

  always_comb begin
    case (tx_state)
      TX_START:  tx_line = 1'b0;
      TX_DATA:   tx_line = tx_shreg[0];
      TX_PARITY: tx_line = tx_par;
      default:   tx_line = 1'b1;
    endcase
    tx_ready      = ~rst & r_tx_en & (tx_state == TX_IDLE);
    int_tx_finish = ~rst & tx_bit_done &
                    (((tx_state == TX_STOP1) & ~tx_stop2) | (tx_state == TX_STOP2));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_sub   <= '0;
      tx_bit   <= '0;
      tx_shreg <= '0;
      tx_mode  <= PARI_NONE;
      tx_stop2 <= 1'b0;
      tx_par   <= 1'b0;
    end else if (tx_fire) begin
      tx_sub   <= '0;
      tx_bit   <= '0;
      tx_shreg <= tx_data;
      tx_mode  <= r_pari_mode;
      tx_stop2 <= r_stop2;
      tx_par   <= pari_bit(MAX_W'(tx_data), DATA_W, r_pari_mode);
    end else if (tx_state != TX_IDLE && tick) begin
      tx_sub <= tx_sub + SUB_W'(1);
      if (tx_sub == SUB_LAST && tx_state == TX_DATA) begin
        tx_shreg <= tx_shreg >> 1;
        tx_bit   <= tx_bit + BIT_W'(1);
      end
    end
  end

  // ---------------- receiver ----------------
  rx_state_t         rx_state, rx_next;
  logic              rx_meta, rx_s;
  logic [SUB_W-1:0]  rx_sub;
  logic [BIT_W-1:0]  rx_bit;
  logic [DATA_W-1:0] rx_shreg;
  logic [1:0]        rx_mode;
  logic              rx_sa, rx_sb, rx_par_s;
  logic              rx_go, rx_mid, rx_bit_done, rx_vote, rx_fin_now;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx_src;
      rx_s    <= rx_meta;
    end
  end

  assign rx_go       = (rx_state == RX_IDLE) & ~rx_s & r_rx_en;
  assign rx_mid      = tick & (rx_sub == SUB_VC);
  assign rx_bit_done = tick & (rx_sub == SUB_LAST);
  assign rx_vote     = (rx_sa & rx_sb) | (rx_sa & rx_s) | (rx_sb & rx_s);

  always_ff @(posedge clk) begin
    if (rst) rx_state <= RX_IDLE;
    else     rx_state <= rx_next;
  end

  always_comb begin
    rx_next = rx_state;
    case (rx_state)
      RX_IDLE:   if (rx_go) rx_next = RX_START;
      RX_START:  if (rx_mid && rx_vote) rx_next = RX_IDLE;
                 else if (rx_bit_done) rx_next = RX_DATA;
      RX_DATA:   if (rx_bit_done && rx_bit == BIT_LAST)
                   rx_next = pari_on(rx_mode) ? RX_PARITY : RX_STOP;
      RX_PARITY: if (rx_bit_done) rx_next = RX_STOP;
      RX_STOP:   if (rx_mid) rx_next = RX_IDLE;
      default:   rx_next = RX_IDLE;
    endcase
  end

  always_comb begin
    rx_fin_now = (rx_state == RX_STOP) & rx_mid;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_sub   <= '0;
      rx_bit   <= '0;
      rx_shreg <= '0;
      rx_mode  <= PARI_NONE;
      rx_sa    <= 1'b1;
      rx_sb    <= 1'b1;
      rx_par_s <= 1'b0;
    end else if (rx_go) begin
      rx_sub  <= '0;
      rx_bit  <= '0;
      rx_mode <= r_pari_mode;
    end else if (rx_state != RX_IDLE && tick) begin
      rx_sub <= rx_sub + SUB_W'(1);
      if (rx_sub == SUB_VA) rx_sa <= rx_s;
      if (rx_sub == SUB_VB) rx_sb <= rx_s;
      if (rx_sub == SUB_VC && rx_state == RX_DATA)   rx_shreg <= {rx_vote, rx_shreg[DATA_W-1:1]};
      if (rx_sub == SUB_VC && rx_state == RX_PARITY) rx_par_s <= rx_vote;
      if (rx_sub == SUB_LAST && rx_state == RX_DATA) rx_bit <= rx_bit + BIT_W'(1);
    end
  end

  // Result registers load together so rx_data and the flags are valid with the pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_valid  <= 1'b0;
      rx_data   <= '0;
      pari_err  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      rx_valid <= rx_fin_now;
      if (rx_fin_now) begin
        rx_data   <= rx_shreg;
        pari_err  <= pari_on(rx_mode) &
                     (rx_par_s != pari_bit(MAX_W'(rx_shreg), DATA_W, rx_mode));
        frame_err <= ~rx_vote;
      end
    end
  end

  assign int_rx_finish = rx_valid;
endmodule

// File: tb/tb_uart_core_param.sv
// Bench for uart_core_param: directed tables, randomized frames vs a frame-level model.
// Covers reset, TX bit timing, RX errors, glitch rejection, 9-bit back-to-back loopback.
module tb_uart_core_param;
  localparam int OVS  = 16;
  localparam int DIV  = 3;
  localparam int BITP = OVS * (DIV + 1);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, rs232_rx, rs232_tx, r_tx_en, r_rx_en, r_stop2, r_loop;
  logic [1:0] r_pari_mode;
  logic [15:0] r_div;
  logic [7:0] tx_data, rx_data;
  logic       tx_valid, tx_ready, rx_valid, pari_err, frame_err, int_tx_finish, int_rx_finish;

  logic       rs232_tx9, r_stop2_9, r_loop9;
  logic [1:0] r_pari_mode9;
  logic [8:0] tx_data9, rx_data9;
  logic       tx_valid9, tx_ready9, rx_valid9, pari_err9, frame_err9, fin_tx9, fin_rx9;

  uart_core_param #(.DATA_W(8), .DIV_W(16), .OVS(OVS)) dut (
    .clk(clk), .rst(rst), .rs232_rx(rs232_rx), .rs232_tx(rs232_tx),
    .r_tx_en(r_tx_en), .r_rx_en(r_rx_en), .r_pari_mode(r_pari_mode), .r_stop2(r_stop2),
    .r_div(r_div), .r_loop(r_loop), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid), .pari_err(pari_err),
    .frame_err(frame_err), .int_tx_finish(int_tx_finish), .int_rx_finish(int_rx_finish)
  );

  // rx9 is tied to tx9 outside as well, so the 9-bit pair loops with or without the macro.
  uart_core_param #(.DATA_W(9), .DIV_W(16), .OVS(OVS)) dut9 (
    .clk(clk), .rst(rst), .rs232_rx(rs232_tx9), .rs232_tx(rs232_tx9),
    .r_tx_en(1'b1), .r_rx_en(1'b1), .r_pari_mode(r_pari_mode9), .r_stop2(r_stop2_9),
    .r_div(r_div), .r_loop(r_loop9), .tx_data(tx_data9), .tx_valid(tx_valid9),
    .tx_ready(tx_ready9), .rx_data(rx_data9), .rx_valid(rx_valid9), .pari_err(pari_err9),
    .frame_err(frame_err9), .int_tx_finish(fin_tx9), .int_rx_finish(fin_rx9)
  );

  int checks = 0, errors = 0, cyc = 0;
  int rx_cnt = 0, sync_bad = 0, fin_cnt = 0, fin_cyc = 0, fin9_cyc = 0, tx9_low = 0;
  logic [7:0] rx_last;
  logic       perr_last, ferr_last;
  logic [8:0] q9[$];
  logic       fb[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst) begin
      if (rx_valid) begin
        rx_cnt <= rx_cnt + 1; rx_last <= rx_data; perr_last <= pari_err; ferr_last <= frame_err;
      end
      if (rx_valid !== int_rx_finish) sync_bad <= sync_bad + 1;
      if (int_tx_finish) begin fin_cnt <= fin_cnt + 1; fin_cyc <= cyc; end
      if (rx_valid9) q9.push_back(rx_data9);
      if (fin_tx9) fin9_cyc <= cyc;
      if (!rs232_tx9) tx9_low <= tx9_low + 1;
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic model_par(input logic [8:0] d, input int w, input logic [1:0] m);
    int ones;
    ones = $countones(d & 9'((1 << w) - 1));
    return (m == 2'b01) ? ((ones % 2) == 0) : ((ones % 2) == 1);
  endfunction

  // Line image of one frame: start, data LSB first, optional parity, stop(s).
  task automatic make_frame(input logic [8:0] d, input int w, input logic [1:0] m,
                            input logic s2, input logic bp, input logic bs);
    fb.delete();
    fb.push_back(1'b0);
    for (int i = 0; i < w; i++) fb.push_back(d[i]);
    if (m == 2'b01 || m == 2'b10) fb.push_back(model_par(d, w, m) ^ bp);
    fb.push_back(~bs);
    if (s2) fb.push_back(1'b1);
  endtask

  task automatic drive_rx();
    foreach (fb[i]) begin
      rs232_rx = fb[i];
      repeat (BITP) @(negedge clk);
    end
    rs232_rx = 1'b1;
    repeat (2 * BITP) @(negedge clk);
  endtask

  task automatic rx_apply(input string name, input logic [7:0] d, input logic [1:0] m,
                          input logic s2, input logic bp, input logic bs,
                          input logic [7:0] ed, input logic ep, input logic ef);
    int n0;
    r_pari_mode = m; r_stop2 = s2;
    make_frame({1'b0, d}, 8, m, s2, bp, bs);
    n0 = rx_cnt;
    drive_rx();
    chk({name, "_cnt"}, rx_cnt - n0, 1);
    chk({name, "_data"}, rx_last, ed);
    chk({name, "_perr"}, perr_last, ep);
    chk({name, "_ferr"}, ferr_last, ef);
  endtask

  // Sends d and compares rs232_tx at each mid-bit against fb; fb is filled by the caller.
  task automatic tx_send(input string name, input logic [7:0] d, input logic [1:0] m,
                         input logic s2);
    int t0, n0, nb, lat, i;
    r_pari_mode = m; r_stop2 = s2;
    i = 0;
    while (!tx_ready && i < 4000) begin @(negedge clk); i++; end
    chk({name, "_ready"}, tx_ready, 1);
    n0 = fin_cnt; nb = fb.size();
    tx_data = d; tx_valid = 1'b1;
    @(posedge clk); #1;
    t0 = cyc; tx_valid = 1'b0;
    for (int k = 0; k < nb; k++) begin
      while (cyc - t0 < k * BITP + BITP / 2) @(negedge clk);
      chk($sformatf("%s_bit%0d", name, k), rs232_tx, fb[k]);
    end
    for (int j = 0; j < 2 * BITP && fin_cnt == n0; j++) @(negedge clk);
    @(negedge clk);
    lat = fin_cyc - t0 + 1;
    checks++;
    if (fin_cnt != n0 + 1 || lat < nb * BITP - DIV || lat > nb * BITP) begin
      errors++;
      $display("FAIL %s_finish: pulses %0d latency %0d, required 1 pulse latency %0d..%0d",
               name, fin_cnt - n0, lat, nb * BITP - DIV, nb * BITP);
    end
  endtask

  typedef struct {
    logic [7:0] d; logic [1:0] m; logic s2, bp, bs;
    logic [7:0] ed; logic ep, ef;
  } rx_vec_t;

  initial begin
    rx_vec_t vec[6];
    int n0, i, hs2;
    logic [7:0] rd; logic [1:0] rm; logic rs2, rbp, rbs;

    rst = 1; rs232_rx = 1; r_tx_en = 1; r_rx_en = 1; r_pari_mode = 0; r_stop2 = 0;
    r_div = 16'(DIV); r_loop = 0; tx_data = 0; tx_valid = 0;
    r_pari_mode9 = 2'b10; r_stop2_9 = 1; r_loop9 = 1; tx_data9 = 0; tx_valid9 = 0;

    vec[0] = '{8'h3C, 2'b10, 1'b0, 1'b0, 1'b0, 8'h3C, 1'b0, 1'b0};
    vec[1] = '{8'h3C, 2'b10, 1'b0, 1'b1, 1'b1, 8'h3C, 1'b1, 1'b1};
    vec[2] = '{8'hA5, 2'b01, 1'b0, 1'b1, 1'b0, 8'hA5, 1'b1, 1'b0};
    vec[3] = '{8'h00, 2'b00, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b1};
    vec[4] = '{8'hFF, 2'b11, 1'b1, 1'b1, 1'b0, 8'hFF, 1'b0, 1'b0};
    vec[5] = '{8'h81, 2'b01, 1'b1, 1'b0, 1'b0, 8'h81, 1'b0, 1'b0};

    repeat (5) @(negedge clk);
    chk("rst_tx_line", rs232_tx, 1);
    chk("rst_tx_ready", tx_ready, 0);
    chk("rst_rx_valid", rx_valid, 0);
    chk("rst_flags", {pari_err, frame_err, int_tx_finish}, 0);
    rst = 0; #1;
    chk("post_rst_ready", tx_ready, 1);
    r_tx_en = 0; #1;
    chk("tx_en_off_ready", tx_ready, 0);
    r_tx_en = 1;
    @(negedge clk);

    fb = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    tx_send("tx_a5_odd", 8'hA5, 2'b01, 1'b0);

    for (int v = 0; v < 6; v++)
      rx_apply($sformatf("rx_vec%0d", v), vec[v].d, vec[v].m, vec[v].s2, vec[v].bp,
               vec[v].bs, vec[v].ed, vec[v].ep, vec[v].ef);

    n0 = rx_cnt;
    rs232_rx = 0;
    repeat (16) @(negedge clk);
    rs232_rx = 1;
    repeat (3 * BITP) @(negedge clk);
    chk("glitch_no_rx", rx_cnt - n0, 0);
    rx_apply("after_glitch", 8'h5A, 2'b00, 1'b0, 1'b0, 1'b0, 8'h5A, 1'b0, 1'b0);

    for (int r = 0; r < 5; r++) begin
      rd = 8'($urandom_range(0, 255)); rm = 2'($urandom_range(0, 3));
      rs2 = 1'($urandom_range(0, 1)); rbp = 1'($urandom_range(0, 1));
      rbs = 1'($urandom_range(0, 1));
      rx_apply($sformatf("rx_rand%0d", r), rd, rm, rs2, rbp, rbs, rd,
               (rm == 2'b01 || rm == 2'b10) & rbp, rbs);
    end
    chk("rx_finish_coincident", sync_bad, 0);

    for (int r = 0; r < 3; r++) begin
      rd = 8'($urandom_range(0, 255)); rm = 2'($urandom_range(0, 3));
      rs2 = 1'($urandom_range(0, 1));
      make_frame({1'b0, rd}, 8, rm, rs2, 1'b0, 1'b0);
      tx_send($sformatf("tx_rand%0d", r), rd, rm, rs2);
    end

    // 9-bit, even parity, 2 stops, back-to-back 0x1FF then 0x001.
    i = 0;
    while (!tx_ready9 && i < 2000) begin @(negedge clk); i++; end
    tx_data9 = 9'h1FF; tx_valid9 = 1;
    @(posedge clk); #1;
    tx_data9 = 9'h001;
    @(negedge clk);
    i = 0;
    while (!tx_ready9 && i < 3000) begin @(negedge clk); i++; end
    chk("b2b_ready", tx_ready9, 1);
    @(posedge clk); #1;
    hs2 = cyc; tx_valid9 = 0;
    chk("b2b_gap", hs2 - fin9_cyc, 2);
    i = 0;
    while (q9.size() < 2 && i < 3000) begin @(negedge clk); i++; end
    chk("loop_cnt", q9.size(), 2);
    if (q9.size() >= 2) begin
      chk("loop_word0", q9[0], 9'h1FF);
      chk("loop_word1", q9[1], 9'h001);
    end
    chk("loop_perr", {pari_err9, frame_err9}, 0);
`ifdef UART_LOOPBACK_EN
    chk("loop_tx_held_high", tx9_low, 0);
`else
    chk("loop_ignored_tx_active", tx9_low > 0, 1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
